chunked_serial_adder: RTL and testbench
=======================================

Name: chunked_serial_adder

Overview:
Multi-cycle, parametrised ripple-carry adder. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then adds them CHUNK bits per clock using a CHUNK-wide chain of full-adder cells. A registered carry links successive chunks. Used in area-constrained datapaths where a full-width single-cycle ripple chain misses timing or costs too much area.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be an integer multiple of CHUNK (elaboration-time assertion).
- CHUNK, 8, bits added per clock; 1 <= CHUNK <= WIDTH. Number of chunks N = WIDTH/CHUNK.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  operands valid.
- o_ready  output  1  block can accept operands.
- i_a  input  WIDTH  operand A.
- i_b  input  WIDTH  operand B.
- i_carry  input  1  carry-in.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_sum  output  WIDTH  sum, registered.
- o_carry  output  1  carry-out of MSB.
- o_overflow  output  1  two's-complement overflow.
- o_busy  output  1  operation in progress (RUN or DONE).

Behaviour:
- Reset (async assert, sync release): state IDLE; o_ready=1, o_valid=0, o_busy=0, o_sum=0, o_carry=0, o_overflow=0; internal operand, carry and chunk-index registers cleared.
- States:
  - IDLE: o_ready=1. On i_valid & o_ready at an edge, capture i_a, i_b and i_carry, clear index k, go to RUN.
  - RUN: o_ready=0, o_busy=1. Each edge adds chunk k (bits k*CHUNK +: CHUNK) of A and B plus the carry register. Write the chunk sum into the result accumulator, update the carry register, and increment k. On the edge processing k=N-1, go to DONE and load o_sum, o_carry and o_overflow.
  - DONE: o_valid=1, o_busy=1, o_ready=0. Outputs are stable while i_ready=0, for any number of cycles. On o_valid & i_ready, go to IDLE at that edge.
- Latency: o_valid rises exactly N edges after the accepting edge. Throughput is one result per N+2 cycles minimum; there is no back-to-back accept in the DONE cycle.
- o_sum, o_carry and o_overflow hold their previous result in IDLE and RUN and change only on DONE entry.
- o_carry is the carry out of bit WIDTH-1.
- o_overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. For CHUNK=1 this is derived from the last two carries.
- Input changes while not in IDLE are ignored; operands are captured.
- i_valid while o_ready=0: not accepted. The source must hold it.
- Reset asserted in RUN or DONE aborts the operation immediately. Outputs return to reset values and no o_valid pulse is produced.
- N=1 (CHUNK=WIDTH): RUN lasts one cycle, so o_valid rises one edge after accept.

Optional Feature:
- Macro: CHUNKED_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port i_sub (input, 1), captured with the operands.
  - i_sub=1 computes A + ~B + ~i_carry, i.e. A - B - borrow_in. o_carry=1 means no borrow; o_overflow uses the same carry rule.
  - i_sub=0 behaves identically to the base block.
- Undefined: port absent; add only.

Test Plan:
- WIDTH=32, CHUNK=8: A=0xFFFFFFFF, B=0x00000001, carry=0 -> after 4 edges o_valid=1, o_sum=0x00000000, o_carry=1, o_overflow=0.
- WIDTH=32, CHUNK=8: A=0x7FFFFFFF, B=0x00000001, carry=0 -> o_sum=0x80000000, o_carry=0, o_overflow=1.
- WIDTH=12, CHUNK=4: A=0xABC, B=0x123, carry=1 -> o_sum=0xBE0, o_carry=0, o_valid 3 edges after accept.
- Backpressure: complete an add with i_ready=0 for 10 cycles -> o_valid, o_sum and o_carry stable, o_ready=0 throughout. Pulse i_ready -> IDLE next cycle, o_ready=1. i_valid pulsed during RUN is not accepted.
- Reset mid-RUN: accept A=0x12345678, drop i_rst_n after 2 edges -> all outputs 0 asynchronously, no o_valid. A new op 0x1+0x2 after release -> o_sum=0x00000003.
- SUB_EN defined: A=0x00000005, B=0x00000007, carry=0, i_sub=1 -> o_sum=0xFFFFFFFE, o_carry=0 (borrow), o_overflow=0.

Source files
------------

// File: rtl/chunked_serial_adder_if.sv
// Handshake and data bundle for chunked_serial_adder.
//
// Upstream (operands):   i_valid, o_ready, i_a, i_b, i_carry (and i_sub when
//                        CHUNKED_SERIAL_ADDER_SUB_EN is defined).
// Downstream (result):   o_valid, i_ready, o_sum, o_carry, o_overflow.
// Status:                o_busy.
//
// Signal names are seen from the adder: i_* are driven by the environment,
// o_* by the adder.
//
// Modports:
//   master - the environment (drives i_*, observes o_*).
//   slave  - the adder       (observes i_*, drives o_*).
//
// Optional feature macro: CHUNKED_SERIAL_ADDER_SUB_EN adds i_sub.
interface chunked_serial_adder_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_carry;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
  logic             i_sub;
`endif
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_overflow;
  logic             o_busy;

  modport master (
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    output i_sub,
`endif
    output i_valid,
    output i_a,
    output i_b,
    output i_carry,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_sum,
    input  o_carry,
    input  o_overflow,
    input  o_busy
  );

  modport slave (
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    input  i_sub,
`endif
    input  i_valid,
    input  i_a,
    input  i_b,
    input  i_carry,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_sum,
    output o_carry,
    output o_overflow,
    output o_busy
  );

endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle ripple-carry adder that processes CHUNK bits per clock.
//
// Operands are captured on an accepted i_valid/o_ready handshake. The adder
// then walks the N = WIDTH/CHUNK chunks from LSB to MSB, one chunk per edge,
// through a CHUNK-wide full-adder chain; a registered carry links the chunks.
// On the last chunk the result is loaded into o_sum/o_carry/o_overflow and
// held under o_valid until i_ready.
//
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset
//   bus      - chunked_serial_adder_if.slave:
//              i_valid/o_ready/i_a/i_b/i_carry  operand handshake
//              o_valid/i_ready/o_sum/o_carry/o_overflow  result handshake
//              o_busy  operation in progress (RUN or DONE)
//
// Optional feature macro: CHUNKED_SERIAL_ADDER_SUB_EN adds bus.i_sub; when set
// the block computes A + ~B + ~i_carry (A - B - borrow_in).
module chunked_serial_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  chunked_serial_adder_if.slave bus
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] KLast = KW'(N - 1);

  if ((CHUNK == 0) || (CHUNK > WIDTH)) begin : g_bad_chunk
    $error("chunked_serial_adder: CHUNK must satisfy 1 <= CHUNK <= WIDTH");
  end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
    $error("chunked_serial_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [KW-1:0]    k_q, k_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] s_chunk;
  logic             chunk_cin_msb;  // carry into the top bit of this chunk
  logic             chunk_cout;

  logic             accept;
  logic             last_chunk;
  logic             b_inv;          // subtract: invert B and the carry-in

  assign accept     = (state_q == StIdle) && bus.i_valid;
  assign last_chunk = (k_q == KLast);

`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
  assign b_inv = bus.i_sub;
`else
  assign b_inv = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.i_valid) state_d = StRun;
      StRun:  if (last_chunk)  state_d = StDone;
      StDone: if (bus.i_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.o_ready    = (state_q == StIdle);
    bus.o_valid    = (state_q == StDone);
    bus.o_busy     = (state_q != StIdle);
    bus.o_sum      = sum_q;
    bus.o_carry    = cout_q;
    bus.o_overflow = ovf_q;
  end

  // ---------------------------------------------------------------------------
  // Chunk select: pick bits k*CHUNK +: CHUNK of the captured operands.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CHUNK-wide ripple of full-adder cells fed by the registered carry.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic c;
    c             = carry_q;
    s_chunk       = '0;
    chunk_cin_msb = carry_q;
    for (int unsigned j = 0; j < CHUNK; j++) begin
      if (j == CHUNK - 1) chunk_cin_msb = c;
      s_chunk[j] = a_chunk[j] ^ b_chunk[j] ^ c;
      c          = (a_chunk[j] & b_chunk[j]) | (c & (a_chunk[j] ^ b_chunk[j]));
    end
    chunk_cout = c;
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    k_d     = k_q;

    if (accept) begin
      a_d     = bus.i_a;
      b_d     = b_inv ? ~bus.i_b : bus.i_b;
      carry_d = b_inv ^ bus.i_carry;
      k_d     = '0;
    end else if (state_q == StRun) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (k_q == KW'(i)) acc_d[i*CHUNK +: CHUNK] = s_chunk;
      end
      carry_d = chunk_cout;
      k_d     = k_q + KW'(1);
      if (last_chunk) begin
        sum_d  = acc_d;
        cout_d = chunk_cout;
        // Signed overflow: carry into the MSB differs from carry out of it.
        ovf_d  = chunk_cin_msb ^ chunk_cout;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      k_q     <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder (WIDTH=32, CHUNK=8).
module tb_chunked_serial_adder;

  localparam int unsigned W = 32;
  localparam int unsigned C = 8;
  localparam int unsigned N = W / C;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  chunked_serial_adder_if #(.WIDTH(W)) bus ();

  chunked_serial_adder #(
    .WIDTH(W),
    .CHUNK(C)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    int unsigned  acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int          rdy_mode = 0;  // 0: random i_ready, 1: bench drives i_ready directly

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: whole-word arithmetic on the operands as the user sees them.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    exp_t         e;
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    bb      = sub ? ~b : b;
    cc      = sub ? ~cin : cin;
    full    = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
    e.sum   = full[W-1:0];
    e.carry = full[W];
    e.ovf   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    e.acc_cyc = 0;
    return e;
  endfunction

  // Issue one operation; push its expectation when push=1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input bit push);
    int   t;
    exp_t e;
    logic sub_eff;
    t = 0;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    sub_eff = sub;
`else
    sub_eff = 1'b0;
`endif
    @(negedge clk);
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_carry = cin;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    bus.i_sub   = sub_eff;
`endif
    bus.i_valid = 1'b1;
    while (!bus.o_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    e         = model(a, b, cin, sub_eff);
    e.acc_cyc = cyc;
    if (push) sb.push_back(e);
    bus.i_valid = 1'b0;
    // Scramble operand lines; the captured copy must be used.
    bus.i_a     = $urandom;
    bus.i_b     = $urandom;
    bus.i_carry = 1'($urandom_range(0, 1));
  endtask

  // Random backpressure source.
  initial begin
    forever begin
      @(negedge clk);
      if (rdy_mode == 0) bus.i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on each new result, checks hold behaviour otherwise.
  initial begin
    logic         prev_v;
    logic [W-1:0] held_sum;
    logic         held_c;
    logic         held_o;
    exp_t         e;
    prev_v   = 1'b0;
    held_sum = '0;
    held_c   = 1'b0;
    held_o   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v   = 1'b0;
        held_sum = '0;
        held_c   = 1'b0;
        held_o   = 1'b0;
      end else begin
        if (bus.o_valid && !prev_v) begin
          if (sb.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("sum", 64'(bus.o_sum), 64'(e.sum));
            check("carry", 64'(bus.o_carry), 64'(e.carry));
            check("overflow", 64'(bus.o_overflow), 64'(e.ovf));
            check("latency", 64'(cyc - e.acc_cyc), 64'(N));
          end
          held_sum = bus.o_sum;
          held_c   = bus.o_carry;
          held_o   = bus.o_overflow;
        end else begin
          check("sum_hold", 64'(bus.o_sum), 64'(held_sum));
          check("carry_hold", 64'(bus.o_carry), 64'(held_c));
          check("ovf_hold", 64'(bus.o_overflow), 64'(held_o));
        end
        if (bus.o_valid) begin
          check("ready_in_done", 64'(bus.o_ready), 64'd0);
          check("busy_in_done", 64'(bus.o_busy), 64'd1);
        end
        prev_v = bus.o_valid;
      end
    end
  end

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.o_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int t;
    bus.i_valid = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_carry = 1'b0;
    bus.i_ready = 1'b0;
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    bus.i_sub   = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", 64'(bus.o_ready), 64'd1);
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_sum", 64'(bus.o_sum), 64'd0);
    check("rst_carry", 64'(bus.o_carry), 64'd0);
    check("rst_ovf", 64'(bus.o_overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases.
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
    issue(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    issue(32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 1'b1);
`ifdef CHUNKED_SERIAL_ADDER_SUB_EN
    issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b1);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1);
`endif
    drain();

    // Backpressure: hold result for 10 cycles, with an i_valid pulse in RUN.
    rdy_mode    = 1;
    bus.i_ready = 1'b0;
    issue(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus.i_a     = 32'hDEAD_BEEF;
    bus.i_b     = 32'hCAFE_F00D;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    t = 0;
    while (!bus.o_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("bp_valid_timeout", 64'd0, 64'd1);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid_held", 64'(bus.o_valid), 64'd1);
      check("bp_ready_low", 64'(bus.o_ready), 64'd0);
    end
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    check("bp_release_ready", 64'(bus.o_ready), 64'd1);
    check("bp_release_valid", 64'(bus.o_valid), 64'd0);
    repeat (3) @(negedge clk);
    check("bp_no_extra_accept", 64'(bus.o_busy), 64'd0);
    rdy_mode = 0;

    // Reset in the middle of RUN: no result, outputs cleared at once.
    issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_valid", 64'(bus.o_valid), 64'd0);
    check("abort_ready", 64'(bus.o_ready), 64'd1);
    check("abort_busy", 64'(bus.o_busy), 64'd0);
    check("abort_sum", 64'(bus.o_sum), 64'd0);
    check("abort_carry", 64'(bus.o_carry), 64'd0);
    check("abort_ovf", 64'(bus.o_overflow), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_valid", 64'(bus.o_valid), 64'd0);
    issue(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
